// File: rtl/piece_write_reg.sv
// Active-piece write buffer: holds the falling-piece overlay plane and applies
// spawn, rotate, hold/swap, shift and drop commands with edge-detected keys.
module piece_write_reg #(
  parameter int         COLS       = 10,
  parameter int         ROWS       = 22,
  parameter int         SPAWN_ROWS = 2,
  parameter logic [7:0] KEY_ROT    = 8'h1A,
  parameter logic [7:0] KEY_SWAP   = 8'h06,
  parameter logic [7:0] KEY_LEFT   = 8'h04,
  parameter logic [7:0] KEY_RIGHT  = 8'h07,
  parameter logic [7:0] KEY_DOWN   = 8'h16,
  parameter logic [2:0] ST_SPAWN   = 3'b000
) (
  input  logic                                Clk,
  input  logic                                Reset_h,
  input  logic [2:0]                          state,
  input  logic [7:0]                          keycode,
  input  logic [SPAWN_ROWS-1:0][COLS-1:0]     new_block,
  input  logic [ROWS-1:0][COLS-1:0]           next_rotation,
  input  logic                                can_rotate,
  input  logic                                can_swap,
  input  logic                                can_left,
  input  logic                                can_right,
  input  logic                                can_drop,
  input  logic                                drop_tick,
  output logic [ROWS-1:0][COLS-1:0]           next_write,
  output logic [SPAWN_ROWS-1:0][COLS-1:0]     hold_block,
  output logic                                hold_valid,
  output logic                                swap_used,
  output logic                                piece_req,
  output logic                                update
);

  logic [ROWS-1:0][COLS-1:0]       plane_q, plane_d;
  logic [SPAWN_ROWS-1:0][COLS-1:0] hold_q, hold_d;
  logic [SPAWN_ROWS-1:0][COLS-1:0] cur_spawn_q, cur_spawn_d;
  logic                            hold_valid_q, hold_valid_d;
  logic                            swap_used_q, swap_used_d;
  logic                            piece_req_q, piece_req_d;
  logic                            update_q, update_d;
  logic [7:0]                      key_prev_q, key_prev_d;
  logic                            was_spawn_q, was_spawn_d;

  logic in_spawn;
  logic do_rot, do_swap, do_left, do_right, do_drop;

  assign in_spawn = (state == ST_SPAWN);
  assign do_rot   = (keycode == KEY_ROT)   && (key_prev_q != KEY_ROT)   && can_rotate;
  assign do_swap  = (keycode == KEY_SWAP)  && (key_prev_q != KEY_SWAP)  && can_swap && !swap_used_q;
  assign do_left  = (keycode == KEY_LEFT)  && (key_prev_q != KEY_LEFT)  && can_left;
  assign do_right = (keycode == KEY_RIGHT) && (key_prev_q != KEY_RIGHT) && can_right;
  assign do_drop  = (((keycode == KEY_DOWN) && (key_prev_q != KEY_DOWN)) || drop_tick) && can_drop;

  always_comb begin
    plane_d      = plane_q;
    hold_d       = hold_q;
    cur_spawn_d  = cur_spawn_q;
    hold_valid_d = hold_valid_q;
    swap_used_d  = swap_used_q;
    piece_req_d  = 1'b0;
    update_d     = 1'b0;
    key_prev_d   = keycode;
    was_spawn_d  = in_spawn;

    if (do_rot) begin
      plane_d  = next_rotation;
      update_d = 1'b1;
    end else if (do_swap) begin
      // Outgoing piece is stored in spawn form, not as its current placement.
      plane_d     = '0;
      swap_used_d = 1'b1;
      update_d    = 1'b1;
      hold_d      = cur_spawn_q;
      if (!hold_valid_q) begin
        hold_valid_d = 1'b1;
        piece_req_d  = 1'b1;
        cur_spawn_d  = new_block;
        for (int k = 0; k < SPAWN_ROWS; k++) plane_d[ROWS-1-k] = new_block[k];
      end else begin
        cur_spawn_d = hold_q;
        for (int k = 0; k < SPAWN_ROWS; k++) plane_d[ROWS-1-k] = hold_q[k];
      end
    end else if (in_spawn) begin
      plane_d     = '0;
      cur_spawn_d = new_block;
      swap_used_d = 1'b0;
      update_d    = !was_spawn_q;
      for (int k = 0; k < SPAWN_ROWS; k++) plane_d[ROWS-1-k] = new_block[k];
    end else if (do_left) begin
      for (int r = 0; r < ROWS; r++) plane_d[r] = plane_q[r] << 1;
      update_d = 1'b1;
    end else if (do_right) begin
      for (int r = 0; r < ROWS; r++) plane_d[r] = plane_q[r] >> 1;
      update_d = 1'b1;
    end else if (do_drop) begin
      for (int r = 0; r < ROWS-1; r++) plane_d[r] = plane_q[r+1];
      plane_d[ROWS-1] = '0;
      update_d        = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      plane_q      <= '0;
      hold_q       <= '0;
      cur_spawn_q  <= '0;
      hold_valid_q <= 1'b0;
      swap_used_q  <= 1'b0;
      piece_req_q  <= 1'b0;
      update_q     <= 1'b0;
      key_prev_q   <= '0;
      was_spawn_q  <= 1'b0;
    end else begin
      plane_q      <= plane_d;
      hold_q       <= hold_d;
      cur_spawn_q  <= cur_spawn_d;
      hold_valid_q <= hold_valid_d;
      swap_used_q  <= swap_used_d;
      piece_req_q  <= piece_req_d;
      update_q     <= update_d;
      key_prev_q   <= key_prev_d;
      was_spawn_q  <= was_spawn_d;
    end
  end

  assign next_write = plane_q;
  assign hold_block = hold_q;
  assign hold_valid = hold_valid_q;
  assign swap_used  = swap_used_q;
  assign piece_req  = piece_req_q;
  assign update     = update_q;

endmodule

// File: tb/tb_piece_write_reg.sv
// Table-driven scoreboard bench for piece_write_reg: each vector is pushed to an
// expected queue when driven and popped/compared one edge later.
module tb_piece_write_reg;

  localparam int COLS = 10;
  localparam int ROWS = 22;
  localparam int SR   = 2;
  localparam logic [2:0] S = 3'b000;
  localparam logic [2:0] P = 3'b001;

  logic                      Clk = 1'b0;
  logic                      Reset_h = 1'b0;
  logic [2:0]                state = P;
  logic [7:0]                keycode = '0;
  logic [SR-1:0][COLS-1:0]   new_block = '0;
  logic [ROWS-1:0][COLS-1:0] next_rotation;
  logic                      can_rotate = 1'b0, can_swap = 1'b0, can_left = 1'b0;
  logic                      can_right = 1'b0, can_drop = 1'b0, drop_tick = 1'b0;
  logic [ROWS-1:0][COLS-1:0] next_write;
  logic [SR-1:0][COLS-1:0]   hold_block;
  logic                      hold_valid, swap_used, piece_req, update;

  piece_write_reg dut (
    .Clk(Clk), .Reset_h(Reset_h), .state(state), .keycode(keycode),
    .new_block(new_block), .next_rotation(next_rotation),
    .can_rotate(can_rotate), .can_swap(can_swap), .can_left(can_left),
    .can_right(can_right), .can_drop(can_drop), .drop_tick(drop_tick),
    .next_write(next_write), .hold_block(hold_block), .hold_valid(hold_valid),
    .swap_used(swap_used), .piece_req(piece_req), .update(update)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string      name;
    logic       rst;
    logic [7:0] key;
    logic [2:0] st;
    logic [4:0] can;  // {rotate, swap, left, right, drop}
    logic       tick;
    logic [9:0] nb0, nb1;
    logic [9:0] e21, e20, e19;
    logic       upd, req, hv, su;
    logic [9:0] h0, h1;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(string name, logic rst, logic [7:0] key, logic [2:0] st,
                              logic [4:0] can, logic tick, logic [9:0] nb0, logic [9:0] nb1,
                              logic [9:0] e21, logic [9:0] e20, logic [9:0] e19,
                              logic upd, logic req, logic hv, logic su,
                              logic [9:0] h0, logic [9:0] h1);
    vec_t v;
    v.name = name; v.rst = rst; v.key = key; v.st = st; v.can = can; v.tick = tick;
    v.nb0 = nb0; v.nb1 = nb1; v.e21 = e21; v.e20 = e20; v.e19 = e19;
    v.upd = upd; v.req = req; v.hv = hv; v.su = su; v.h0 = h0; v.h1 = h1;
    return v;
  endfunction

  task automatic chk(string nm, logic [255:0] got, logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic apply(vec_t v);
    @(negedge Clk);
    Reset_h    = v.rst;
    keycode    = v.key;
    state      = v.st;
    {can_rotate, can_swap, can_left, can_right, can_drop} = v.can;
    drop_tick  = v.tick;
    new_block[0] = v.nb0;
    new_block[1] = v.nb1;
    exp_q.push_back(v);
  endtask

  task automatic check_out();
    vec_t e;
    logic [ROWS-1:0][COLS-1:0] ep;
    logic [SR-1:0][COLS-1:0]   eh;
    e  = exp_q.pop_front();
    ep = '0;
    ep[21] = e.e21; ep[20] = e.e20; ep[19] = e.e19;
    eh[0] = e.h0; eh[1] = e.h1;
    chk({e.name, ".plane"},      256'(next_write), 256'(ep));
    chk({e.name, ".update"},     256'(update),     256'(e.upd));
    chk({e.name, ".piece_req"},  256'(piece_req),  256'(e.req));
    chk({e.name, ".hold_valid"}, 256'(hold_valid), 256'(e.hv));
    chk({e.name, ".swap_used"},  256'(swap_used),  256'(e.su));
    chk({e.name, ".hold_block"}, 256'(hold_block), 256'(eh));
  endtask

  initial begin
    next_rotation     = '0;
    next_rotation[21] = 10'h010;
    next_rotation[20] = 10'h038;

    //             name         rst key    st can      tk nb0     nb1     e21     e20     e19     up rq hv su h0      h1
    tbl.push_back(mk("reset",    1, 8'h00, P, 5'b00000, 0, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 0, 0, 0, 0, 10'h000, 10'h000));
    tbl.push_back(mk("spawn1",   0, 8'h00, S, 5'b00000, 0, 10'h030, 10'h030, 10'h030, 10'h030, 10'h000, 1, 0, 0, 0, 10'h000, 10'h000));
    tbl.push_back(mk("spawn2",   0, 8'h00, S, 5'b00000, 0, 10'h030, 10'h030, 10'h030, 10'h030, 10'h000, 0, 0, 0, 0, 10'h000, 10'h000));
    tbl.push_back(mk("left1",    0, 8'h04, P, 5'b00100, 0, 10'h0F0, 10'h000, 10'h060, 10'h060, 10'h000, 1, 0, 0, 0, 10'h000, 10'h000));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk("left_held", 0, 8'h04, P, 5'b00100, 0, 10'h0F0, 10'h000, 10'h060, 10'h060, 10'h000, 0, 0, 0, 0, 10'h000, 10'h000));
    tbl.push_back(mk("left_rel", 0, 8'h00, P, 5'b00100, 0, 10'h0F0, 10'h000, 10'h060, 10'h060, 10'h000, 0, 0, 0, 0, 10'h000, 10'h000));
    tbl.push_back(mk("left2",    0, 8'h04, P, 5'b00100, 0, 10'h0F0, 10'h000, 10'h0C0, 10'h0C0, 10'h000, 1, 0, 0, 0, 10'h000, 10'h000));
    tbl.push_back(mk("rel1",     0, 8'h00, P, 5'b00000, 0, 10'h0F0, 10'h000, 10'h0C0, 10'h0C0, 10'h000, 0, 0, 0, 0, 10'h000, 10'h000));
    tbl.push_back(mk("swap1",    0, 8'h06, P, 5'b01000, 0, 10'h0F0, 10'h000, 10'h0F0, 10'h000, 10'h000, 1, 1, 1, 1, 10'h030, 10'h030));
    tbl.push_back(mk("rel2",     0, 8'h00, P, 5'b01000, 0, 10'h0F0, 10'h000, 10'h0F0, 10'h000, 10'h000, 0, 0, 1, 1, 10'h030, 10'h030));
    tbl.push_back(mk("swap2",    0, 8'h06, P, 5'b01000, 0, 10'h0F0, 10'h000, 10'h0F0, 10'h000, 10'h000, 0, 0, 1, 1, 10'h030, 10'h030));
    tbl.push_back(mk("rel3",     0, 8'h00, P, 5'b00000, 0, 10'h0F0, 10'h000, 10'h0F0, 10'h000, 10'h000, 0, 0, 1, 1, 10'h030, 10'h030));
    tbl.push_back(mk("respawn",  0, 8'h00, S, 5'b00000, 0, 10'h3C0, 10'h000, 10'h3C0, 10'h000, 10'h000, 1, 0, 1, 0, 10'h030, 10'h030));
    tbl.push_back(mk("swap3",    0, 8'h06, P, 5'b01000, 0, 10'h3FF, 10'h3FF, 10'h030, 10'h030, 10'h000, 1, 0, 1, 1, 10'h3C0, 10'h000));
    tbl.push_back(mk("rel4",     0, 8'h00, P, 5'b00000, 0, 10'h3FF, 10'h3FF, 10'h030, 10'h030, 10'h000, 0, 0, 1, 1, 10'h3C0, 10'h000));
    tbl.push_back(mk("rot_tick", 0, 8'h1A, P, 5'b10001, 1, 10'h000, 10'h000, 10'h010, 10'h038, 10'h000, 1, 0, 1, 1, 10'h3C0, 10'h000));
    tbl.push_back(mk("tick_blk", 0, 8'h00, P, 5'b00000, 1, 10'h000, 10'h000, 10'h010, 10'h038, 10'h000, 0, 0, 1, 1, 10'h3C0, 10'h000));
    tbl.push_back(mk("down_tick",0, 8'h16, P, 5'b00001, 1, 10'h000, 10'h000, 10'h000, 10'h010, 10'h038, 1, 0, 1, 1, 10'h3C0, 10'h000));
    tbl.push_back(mk("down_held",0, 8'h16, P, 5'b00001, 0, 10'h000, 10'h000, 10'h000, 10'h010, 10'h038, 0, 0, 1, 1, 10'h3C0, 10'h000));
    tbl.push_back(mk("right",    0, 8'h07, P, 5'b00010, 0, 10'h000, 10'h000, 10'h000, 10'h008, 10'h01C, 1, 0, 1, 1, 10'h3C0, 10'h000));
    tbl.push_back(mk("rot_gated",0, 8'h1A, P, 5'b00000, 0, 10'h000, 10'h000, 10'h000, 10'h008, 10'h01C, 0, 0, 1, 1, 10'h3C0, 10'h000));

    foreach (tbl[i]) begin
      apply(tbl[i]);
      @(posedge Clk); #1;
      check_out();
    end

    // Reset lands on the same edge as a fresh KEY_DOWN press.
    apply(mk("rst_down", 1, 8'h16, P, 5'b00001, 0, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 0, 0, 0, 0, 10'h000, 10'h000));
    @(posedge Clk); #1;
    check_out();
    // key_prev was cleared by reset, so the still-held KEY_DOWN counts as a new press.
    apply(mk("post_rst", 0, 8'h16, P, 5'b00001, 0, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 1, 0, 0, 0, 10'h000, 10'h000));
    @(posedge Clk); #1;
    check_out();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/piece_write_reg.md
Name: piece_write_reg

Overview:
- Parametrised active-piece write buffer for the Tetris playfield.
- Holds the falling-piece overlay plane (ROWS x COLS bits) that the board merger reads.
- Applies spawn, rotate, hold/swap, lateral shift, soft drop and gravity drop.
- Owns the hold register, enforces one swap per piece, and edge-detects keycodes so held keys act once.

Parameters:
- COLS, 10, playfield width in bits per row.
- ROWS, 22, playfield height; row ROWS-1 is the top.
- SPAWN_ROWS, 2, rows occupied by a spawn-form piece; loaded into rows ROWS-1 down to ROWS-SPAWN_ROWS.
- KEY_ROT, 8'h1A, rotate keycode.
- KEY_SWAP, 8'h06, hold/swap keycode.
- KEY_LEFT, 8'h04, shift-left keycode.
- KEY_RIGHT, 8'h07, shift-right keycode.
- KEY_DOWN, 8'h16, soft-drop keycode.
- ST_SPAWN, 3'b000, game-state encoding for spawn.

Ports:
- Clk  in  1  system clock.
- Reset_h  in  1  synchronous active-high reset.
- state  in  3  game FSM state.
- keycode  in  8  current keyboard code; 0 = none.
- new_block  in  SPAWN_ROWS x COLS  next piece, spawn form; element 0 = top row.
- next_rotation  in  ROWS x COLS  precomputed rotated plane.
- can_rotate  in  1  rotation legal.
- can_swap  in  1  swap legal (board side).
- can_left  in  1  left shift collision-free.
- can_right  in  1  right shift collision-free.
- can_drop  in  1  one-row drop collision-free.
- drop_tick  in  1  gravity pulse.
- next_write  out  ROWS x COLS  registered active-piece plane.
- hold_block  out  SPAWN_ROWS x COLS  held piece, spawn form.
- hold_valid  out  1  hold register occupied.
- swap_used  out  1  swap already used for the current piece.
- piece_req  out  1  one-cycle pulse: consume new_block and advance the generator.
- update  out  1  one-cycle pulse: next_write changed this cycle.

Behaviour:
- Reset values: all plane rows 0, hold_block 0, cur_spawn 0, hold_valid 0, swap_used 0, piece_req 0, update 0, key_prev 0.
- Reset mid-operation aborts any command; no pulse is emitted in the reset cycle.
- Edge detect:
  - press(K) = (keycode == K) && (key_prev != K).
  - key_prev <= keycode every non-reset cycle.
  - A held key acts once; release followed by re-press acts again.
- Latency: a command sampled at edge n is visible on next_write after edge n. update and piece_req are registered and high during the cycle after edge n.
- Priority per cycle (first match wins; exactly one action):
  1. press(KEY_ROT) && can_rotate -> plane <= next_rotation.
  2. press(KEY_SWAP) && can_swap && !swap_used:
     - swap_used <= 1; rows below the spawn region <= 0.
     - If !hold_valid: hold_block <= cur_spawn; hold_valid <= 1; spawn rows <= new_block; cur_spawn <= new_block; piece_req pulse.
     - Else: hold_block <= cur_spawn; spawn rows <= hold_block; cur_spawn <= hold_block; no piece_req.
  3. state == ST_SPAWN -> spawn rows <= new_block; other rows 0; cur_spawn <= new_block; swap_used <= 0.
     - Level-sensitive; reloads every cycle while in spawn.
     - update only on the first spawn cycle (state was not ST_SPAWN the previous cycle).
  4. press(KEY_LEFT) && can_left -> each row <= row << 1; MSB lost, LSB 0.
  5. press(KEY_RIGHT) && can_right -> each row <= row >> 1.
  6. (press(KEY_DOWN) || drop_tick) && can_drop -> row[i] <= row[i+1] for i < ROWS-1; row[ROWS-1] <= 0. Simultaneous key and tick drop exactly one row.
  7. Otherwise hold.
- A gated-off command (can_* = 0) is consumed: no change, no update. The key still needs re-press.
- The shifters themselves do not check wall/collision; the can_* inputs are the only gate.
- update = 1 for every applied case 1, 2, 4, 5, 6, and for the first spawn cycle.

Test Plan:
- Reset, then state=ST_SPAWN, new_block={10'h030,10'h030} -> after one edge rows 21,20 = 10'h030, others 0; update pulses once; swap_used=0.
- Hold KEY_LEFT for 5 cycles with can_left=1 from the spawn plane above -> rows 21,20 = 10'h060 after first edge only; single update pulse; release and re-press -> 10'h0C0.
- First KEY_SWAP with hold empty, new_block=10'h0F0/0 -> hold_block = previous spawn form, hold_valid=1, piece_req one-cycle pulse, plane top = 10'h0F0. Second KEY_SWAP before spawn -> ignored, swap_used stays 1.
- Re-enter ST_SPAWN, then KEY_SWAP with hold_valid=1 -> spawn rows = old hold_block, hold_block = cur piece, no piece_req.
- KEY_ROT press and drop_tick same cycle, can_rotate=1, can_drop=1 -> plane = next_rotation, no drop. drop_tick alone with can_drop=0 -> unchanged, update=0.
- Reset_h asserted during a KEY_DOWN press -> plane 0, hold_valid 0; no update pulse in the reset cycle.
